// File: rtl/mux8to1_pkg.sv
// rtl/mux8to1_pkg.sv - shared widths and select type for the 8-to-1 mux
package mux8to1_pkg;

    localparam int N_IN  = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux8to1_dec.sv
// rtl/mux8to1_dec.sv - 3-to-8 one-hot decoder feeding the mux datapath
module mux8to1_dec
    import mux8to1_pkg::*;
(
    input  sel_t            sel,
    output logic [N_IN-1:0] onehot
);

    // An unknown select shifts to all-X, so the mux output goes X with no fallback.
    assign onehot = {{(N_IN-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/mux8to1.sv
// rtl/mux8to1.sv - 8-to-1 bit mux with registered capture; MUX8TO1_ONEHOT_EN adds sel_oh
module mux8to1
    import mux8to1_pkg::*;
#(
    parameter logic RST_Y = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] d,
    input  sel_t            sel,
    input  logic            en,
    output logic            y,
    output logic            y_q,
    output sel_t            sel_q,
    output logic            vld_q
`ifdef MUX8TO1_ONEHOT_EN
    ,
    output logic [N_IN-1:0] sel_oh
`endif
);

    logic [N_IN-1:0] onehot;

    mux8to1_dec u_dec (
        .sel    (sel),
        .onehot (onehot)
    );

    assign y = |(d & onehot);

`ifdef MUX8TO1_ONEHOT_EN
    assign sel_oh = onehot;
`endif

    // Reset wins over enable; y itself is purely combinational and never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= RST_Y;
            sel_q <= '0;
            vld_q <= 1'b0;
        end else if (en) begin
            y_q   <= y;
            sel_q <= sel;
            vld_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux8to1.sv
// tb/tb_mux8to1.sv - self-checking bench for mux8to1 against a behavioural model
module tb_mux8to1;

    localparam logic RST_Y = 1'b1;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [2:0] sel;
    logic       en;
    logic       y;
    logic       y_q;
    logic [2:0] sel_q;
    logic       vld_q;
`ifdef MUX8TO1_ONEHOT_EN
    logic [7:0] sel_oh;
`endif

    int total = 0;
    int bad   = 0;

    logic       exp_yq;
    logic [2:0] exp_selq;
    logic       exp_vld;

    mux8to1 #(.RST_Y(RST_Y)) dut (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .sel    (sel),
        .en     (en),
        .y      (y),
        .y_q    (y_q),
        .sel_q  (sel_q),
        .vld_q  (vld_q)
`ifdef MUX8TO1_ONEHOT_EN
        ,
        .sel_oh (sel_oh)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic ref_mux(input logic [7:0] dd, input int s);
        return logic'((dd >> s) & 8'd1);
    endfunction

    task automatic edge_and_model();
        @(posedge clk);
        if (rst) begin
            exp_yq   = RST_Y;
            exp_selq = 3'd0;
            exp_vld  = 1'b0;
        end else if (en) begin
            exp_yq   = ref_mux(d, int'(sel));
            exp_selq = sel;
            exp_vld  = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_yq"},  8'(y_q),   8'(exp_yq));
        check({tag, "_selq"}, 8'(sel_q), 8'(exp_selq));
        check({tag, "_vld"}, 8'(vld_q), 8'(exp_vld));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d = 8'h00; sel = 3'd0;
        exp_yq = 1'b0; exp_selq = 3'd0; exp_vld = 1'b0;

        // combinational sweep while reset is held
        d = 8'b10101010;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #10;
            check("sweep_y", 8'(y), 8'(s % 2));
        end

        @(negedge clk);
        edge_and_model();
        check_regs("reset");

        // registered capture
        rst = 1'b0; d = 8'hAA; sel = 3'd5; en = 1'b1;
        edge_and_model();
        check("cap_yq",   8'(y_q),   8'd1);
        check("cap_selq", 8'(sel_q), 8'd5);
        check("cap_vld",  8'(vld_q), 8'd1);

        // hold with en low
        en = 1'b0; d = 8'h00;
        #1;
        check("hold_y", 8'(y), 8'd0);
        for (int i = 0; i < 4; i++) begin
            edge_and_model();
            check("hold_yq", 8'(y_q), 8'd1);
            check("hold_vld", 8'(vld_q), 8'd1);
        end

        // reset beats enable
        rst = 1'b1; en = 1'b1; d = 8'hFF; sel = 3'd6;
        #1;
        check("rstpri_y", 8'(y), 8'd1);
        edge_and_model();
        check("rstpri_yq",   8'(y_q),   8'(RST_Y));
        check("rstpri_selq", 8'(sel_q), 8'd0);
        check("rstpri_vld",  8'(vld_q), 8'd0);
        check("rstpri_y2",   8'(y),     8'd1);

        // capture resumes on first enabled edge after reset
        rst = 1'b0; en = 1'b1; d = 8'h08; sel = 3'd3;
        edge_and_model();
        check("resume_yq",   8'(y_q),   8'd1);
        check("resume_selq", 8'(sel_q), 8'd3);
        check("resume_vld",  8'(vld_q), 8'd1);

        // exhaustive combinational check
        en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int s = 0; s < 8; s++) begin
                d = 8'(i);
                sel = 3'(s);
                #1;
                check("exh_y", 8'(y), 8'(ref_mux(8'(i), s)));
`ifdef MUX8TO1_ONEHOT_EN
                check("exh_oh", sel_oh, 8'(1 << s));
`endif
            end
        end

        // randomized traffic against the model
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 15) == 0);
            en  = 1'(($urandom_range(0, 2) != 0));
            d   = 8'($urandom);
            sel = 3'($urandom);
            #1;
            check("rnd_y", 8'(y), 8'(ref_mux(d, int'(sel))));
            edge_and_model();
            check_regs("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
